// File: rtl/reduce_gate_pipe.sv
// Pipelined multi-channel reduction gate (AND/OR/XOR/NAND) built from registered FANIN-input tree levels.
// Optional build macro REDUCE_GATE_ACT_CNT_EN adds a 16-bit act_cnt output counting changes of valid out_data.
module reduce_gate_pipe #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 1,
  parameter int FANIN    = 4
) (
  input  logic                      gclk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out_data
`ifdef REDUCE_GATE_ACT_CNT_EN
  ,
  output logic [15:0]               act_cnt
`endif
);

  // Valid semantics: a sample is accepted when in_valid && en; there is no ready,
  // so in_valid with en low is dropped. out_valid marks out_data as meaningful.

  function automatic int calc_lat();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      l++;
    end
    return (l == 0) ? 1 : l;
  endfunction

  localparam int LAT = calc_lat();

  function automatic int lvl_cnt(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i < k; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  // One tree level: node j folds inputs j*FANIN .. j*FANIN+FANIN-1, with
  // missing inputs replaced by the identity of the operation.
  function automatic logic [WIDTH-1:0] reduce_level(input logic [WIDTH-1:0] src,
                                                    input int cnt,
                                                    input logic [1:0] op);
    logic [WIDTH*FANIN-1:0] pad;
    logic [FANIN-1:0]       grp;
    logic [WIDTH-1:0]       res;
    logic                   idn;
    idn = (op == 2'b00) || (op == 2'b11);
    pad = {(WIDTH*FANIN){idn}};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < cnt) pad[i] = src[i];
    end
    res = '0;
    for (int j = 0; j < WIDTH; j++) begin
      grp = pad[j*FANIN +: FANIN];
      case (op)
        2'b01:   res[j] = |grp;
        2'b10:   res[j] = ^grp;
        default: res[j] = &grp;
      endcase
    end
    return res;
  endfunction

  // Root node: at most FANIN live inputs remain, identity padding is implicit.
  function automatic logic reduce_root(input logic [WIDTH-1:0] src,
                                       input int cnt,
                                       input logic [1:0] op);
    logic acc;
    acc = (op == 2'b00) || (op == 2'b11);
    for (int i = 0; i < WIDTH; i++) begin
      if (i < cnt) begin
        case (op)
          2'b01:   acc = acc | src[i];
          2'b10:   acc = acc ^ src[i];
          default: acc = acc & src[i];
        endcase
      end
    end
    return acc;
  endfunction

  logic [CHANNELS*WIDTH-1:0] last_data;
  logic [1:0]                last_mode;
  logic                      last_vld;

  if (LAT > 1) begin : g_mid
    logic [CHANNELS*WIDTH-1:0] lvl_q  [LAT-1];
    logic [CHANNELS*WIDTH-1:0] lvl_d  [LAT-1];
    logic [1:0]                mode_q [LAT-1];
    logic [1:0]                mode_d [LAT-1];
    logic [LAT-2:0]            vld_q;
    logic [LAT-2:0]            vld_d;

    always_comb begin
      for (int s = 0; s < LAT-1; s++) begin
        lvl_d[s]  = '0;
        mode_d[s] = 2'b00;
      end
      vld_d     = '0;
      mode_d[0] = mode;
      vld_d[0]  = in_valid;
      for (int c = 0; c < CHANNELS; c++) begin
        lvl_d[0][c*WIDTH +: WIDTH] = reduce_level(in_data[c*WIDTH +: WIDTH], WIDTH, mode);
      end
      for (int s = 1; s < LAT-1; s++) begin
        mode_d[s] = mode_q[s-1];
        vld_d[s]  = vld_q[s-1];
        for (int c = 0; c < CHANNELS; c++) begin
          lvl_d[s][c*WIDTH +: WIDTH] =
            reduce_level(lvl_q[s-1][c*WIDTH +: WIDTH], lvl_cnt(s), mode_q[s-1]);
        end
      end
    end

    always_ff @(posedge gclk) begin
      if (reset) begin
        for (int s = 0; s < LAT-1; s++) begin
          lvl_q[s]  <= '0;
          mode_q[s] <= 2'b00;
        end
        vld_q <= '0;
      end else if (en) begin
        for (int s = 0; s < LAT-1; s++) begin
          lvl_q[s]  <= lvl_d[s];
          mode_q[s] <= mode_d[s];
        end
        vld_q <= vld_d;
      end
    end

    assign last_data = lvl_q[LAT-2];
    assign last_mode = mode_q[LAT-2];
    assign last_vld  = vld_q[LAT-2];
  end else begin : g_nomid
    assign last_data = in_data;
    assign last_mode = mode;
    assign last_vld  = in_valid;
  end

  logic [CHANNELS-1:0] out_data_q;
  logic [CHANNELS-1:0] out_data_d;
  logic                out_valid_q;
  logic                out_valid_d;

  // NAND travels as AND through the tree and is inverted only here.
  always_comb begin
    out_valid_d = last_vld;
    out_data_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_data_d[c] = reduce_root(last_data[c*WIDTH +: WIDTH], lvl_cnt(LAT-1), last_mode)
                      ^ (last_mode == 2'b11);
    end
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef REDUCE_GATE_ACT_CNT_EN
  logic [15:0]         act_cnt_q;
  logic [15:0]         act_cnt_d;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] prev_d;

  // Counted as each valid result is loaded, so act_cnt lines up with out_data.
  always_comb begin
    act_cnt_d = act_cnt_q;
    prev_d    = prev_q;
    if (en && out_valid_d) begin
      if ((out_data_d != prev_q) && (act_cnt_q != 16'hFFFF)) act_cnt_d = act_cnt_q + 16'd1;
      prev_d = out_data_d;
    end
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      act_cnt_q <= '0;
      prev_q    <= '0;
    end else begin
      act_cnt_q <= act_cnt_d;
      prev_q    <= prev_d;
    end
  end

  assign act_cnt = act_cnt_q;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Bench for reduce_gate_pipe: four instances (L=1,3,2,1) share control; a popcount model
// and per-instance expected queues keyed by enabled-cycle index predict every output.
module tb_reduce_gate_pipe;

  localparam int LA = 1;
  localparam int LB = 3;
  localparam int LC = 2;
  localparam int LD = 1;

  logic        gclk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [1:0]  mode;
  logic [2:0]  da;
  logic [33:0] db;
  logic [15:0] dc;
  logic [3:0]  dd;

  logic        ova, ovb, ovc, ovd;
  logic [0:0]  oda;
  logic [1:0]  odb;
  logic [0:0]  odc;
  logic [3:0]  odd;

  always #5 gclk = ~gclk;

  reduce_gate_pipe #(.WIDTH(3), .CHANNELS(1), .FANIN(4)) dut_a (
    .gclk(gclk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
    .in_data(da), .out_valid(ova), .out_data(oda));
  reduce_gate_pipe #(.WIDTH(17), .CHANNELS(2), .FANIN(4)) dut_b (
    .gclk(gclk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
    .in_data(db), .out_valid(ovb), .out_data(odb));
  reduce_gate_pipe #(.WIDTH(16), .CHANNELS(1), .FANIN(4)) dut_c (
    .gclk(gclk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
    .in_data(dc), .out_valid(ovc), .out_data(odc));
  reduce_gate_pipe #(.WIDTH(1), .CHANNELS(4), .FANIN(2)) dut_d (
    .gclk(gclk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
    .in_data(dd), .out_valid(ovd), .out_data(odd));

  // Scoreboard entries: {accept index[15:0], expected result[3:0]}
  logic [19:0] exp_qa[$];
  logic [19:0] exp_qb[$];
  logic [19:0] exp_qc[$];
  logic [19:0] exp_qd[$];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ecnt     = 0;
  logic       rst_seen = 1'b0;
  logic       exp_va = 1'b0, exp_vb = 1'b0, exp_vc = 1'b0, exp_vd = 1'b0;
  logic [3:0] exp_da = '0, exp_db = '0, exp_dc = '0, exp_dd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reduction from the bit count of the w low bits.
  function automatic logic ref_bit(input logic [16:0] v, input int w, input logic [1:0] m);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(v[i]);
    case (m)
      2'b00:   return ones == w;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones != w;
    endcase
  endfunction

  task automatic rand_data();
    da = 3'($urandom());
    db = 34'({$urandom(), $urandom()});
    dc = 16'($urandom());
    dd = 4'($urandom());
  endtask

  task automatic tick();
    logic [3:0] ra, rb, rc, rd;
    int idx;
    @(posedge gclk);
    if (reset) begin
      exp_qa.delete(); exp_qb.delete(); exp_qc.delete(); exp_qd.delete();
      exp_va = 1'b0; exp_vb = 1'b0; exp_vc = 1'b0; exp_vd = 1'b0;
      rst_seen = 1'b1;
    end else if (en) begin
      rst_seen = 1'b0;
      if (in_valid) begin
        ra = {3'b0, ref_bit({14'b0, da}, 3, mode)};
        rb = {2'b0, ref_bit(db[33:17], 17, mode), ref_bit(db[16:0], 17, mode)};
        rc = {3'b0, ref_bit({1'b0, dc}, 16, mode)};
        for (int c = 0; c < 4; c++) rd[c] = ref_bit({16'b0, dd[c]}, 1, mode);
        exp_qa.push_back({16'(ecnt), ra});
        exp_qb.push_back({16'(ecnt), rb});
        exp_qc.push_back({16'(ecnt), rc});
        exp_qd.push_back({16'(ecnt), rd});
      end
      idx = ecnt - LA + 1;
      exp_va = (exp_qa.size() > 0) && (int'(exp_qa[0][19:4]) == idx);
      if (exp_va) begin exp_da = exp_qa[0][3:0]; void'(exp_qa.pop_front()); end
      idx = ecnt - LB + 1;
      exp_vb = (exp_qb.size() > 0) && (int'(exp_qb[0][19:4]) == idx);
      if (exp_vb) begin exp_db = exp_qb[0][3:0]; void'(exp_qb.pop_front()); end
      idx = ecnt - LC + 1;
      exp_vc = (exp_qc.size() > 0) && (int'(exp_qc[0][19:4]) == idx);
      if (exp_vc) begin exp_dc = exp_qc[0][3:0]; void'(exp_qc.pop_front()); end
      idx = ecnt - LD + 1;
      exp_vd = (exp_qd.size() > 0) && (int'(exp_qd[0][19:4]) == idx);
      if (exp_vd) begin exp_dd = exp_qd[0][3:0]; void'(exp_qd.pop_front()); end
      ecnt++;
    end
    #1;
    check("a_vld", 32'(ova), 32'(exp_va));
    if (exp_va) check("a_dat", 32'(oda), 32'(exp_da[0]));
    check("b_vld", 32'(ovb), 32'(exp_vb));
    if (exp_vb) check("b_dat", 32'(odb), 32'(exp_db[1:0]));
    check("c_vld", 32'(ovc), 32'(exp_vc));
    if (exp_vc) check("c_dat", 32'(odc), 32'(exp_dc[0]));
    check("d_vld", 32'(ovd), 32'(exp_vd));
    if (exp_vd) check("d_dat", 32'(odd), 32'(exp_dd));
    if (rst_seen) check("rst_dat", 32'({odd, odc, odb, oda}), 32'h0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; mode = 2'b00;
    da = '0; db = '0; dc = '0; dd = '0;
    tick(); tick();
    reset = 1'b0;

    // AND on 3 bits: 111 -> 1, 101 -> 0, one cycle later each
    mode = 2'b00; in_valid = 1'b1; rand_data(); da = 3'b111;
    tick();
    check("t1_and_111", 32'(oda), 32'h1);
    rand_data(); da = 3'b101;
    tick();
    check("t1_and_101", 32'(oda), 32'h0);
    in_valid = 1'b0;
    tick();

    // XOR with padding on 17 bits, then NAND all-ones the next cycle
    mode = 2'b10; in_valid = 1'b1; rand_data(); db = {17'h10003, 17'h00001};
    tick();
    mode = 2'b11; rand_data(); db = '1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // OR of zero, then en low for 5 cycles with in_valid held high
    mode = 2'b01; in_valid = 1'b1; rand_data(); dc = 16'h0000;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data(); mode = 2'($urandom_range(0, 3));
      tick();
    end
    en = 1'b1; in_valid = 1'b0;
    repeat (3) tick();

    // Reset with samples in flight, then AND of all-ones
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_data(); mode = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0; mode = 2'b00; in_valid = 1'b1; rand_data(); dc = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4_and_vld", 32'(ovc), 32'h1);
    check("t4_and_ffff", 32'(odc), 32'h1);
    repeat (3) tick();

    // Continuous stream, all modes
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_data(); mode = 2'($urandom_range(0, 3));
      tick();
    end

    // Random en / in_valid / occasional reset
    for (int i = 0; i < 300; i++) begin
      rand_data(); mode = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 7);
      reset    = ($urandom_range(0, 49) == 0);
      tick();
    end

    reset = 1'b0; en = 1'b1; in_valid = 1'b0;
    repeat (4) tick();
    check("drain_empty", 32'(exp_qa.size() + exp_qb.size() + exp_qc.size() + exp_qd.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
